// File: rtl/uart_pkg.sv
// Shared UART definitions: baud/parity codes, divisor table and FSM state encoding.
// Used by both the transmitter and the oversampling receiver.
package uart_pkg;

  localparam logic [1:0] Baud2400  = 2'b00;
  localparam logic [1:0] Baud4800  = 2'b01;
  localparam logic [1:0] Baud9600  = 2'b10;
  localparam logic [1:0] Baud19200 = 2'b11;

  localparam logic [1:0] ParNone    = 2'b00;
  localparam logic [1:0] ParOdd     = 2'b01;
  localparam logic [1:0] ParEven    = 2'b10;
  localparam logic [1:0] ParNoneAlt = 2'b11;

  localparam int BaudCntWidth = 15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uartState_t;

  function automatic int baudHz(input logic [1:0] code);
    int hz;
    case (code)
      Baud2400:  hz = 2400;
      Baud4800:  hz = 4800;
      Baud9600:  hz = 9600;
      default:   hz = 19200;
    endcase
    return hz;
  endfunction

  // Rounded ClkFreq/baud; only ever evaluated with constant arguments.
  function automatic logic [BaudCntWidth-1:0] baudDivisor(input int clkFreq, input logic [1:0] code);
    int hz;
    hz = baudHz(code);
    return BaudCntWidth'((clkFreq + hz / 2) / hz);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 1x bit-period generator: one-cycle Tick when the counter reaches Divisor-1.
// Clear holds the counter at zero so the first bit after release is a full period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int ClkFreq = 50_000_000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic [1:0] BaudRate,
  output logic       Tick
);

  localparam logic [BaudCntWidth-1:0] Div0 = baudDivisor(ClkFreq, Baud2400);
  localparam logic [BaudCntWidth-1:0] Div1 = baudDivisor(ClkFreq, Baud4800);
  localparam logic [BaudCntWidth-1:0] Div2 = baudDivisor(ClkFreq, Baud9600);
  localparam logic [BaudCntWidth-1:0] Div3 = baudDivisor(ClkFreq, Baud19200);

  logic [BaudCntWidth-1:0] divisor;
  logic [BaudCntWidth-1:0] baudCnt;

  always_comb begin
    divisor = Div3;
    case (BaudRate)
      Baud2400:  divisor = Div0;
      Baud4800:  divisor = Div1;
      Baud9600:  divisor = Div2;
      default:   divisor = Div3;
    endcase
  end

  assign Tick = !Clear && (baudCnt == divisor - BaudCntWidth'(1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      baudCnt <= '0;
    end else if (Clear || Tick) begin
      baudCnt <= '0;
    end else begin
      baudCnt <= baudCnt + BaudCntWidth'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits. TxOut falls on the
// accept edge; Send is only sampled in IDLE (no queue), so requests while Busy are dropped.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int ClkFreq   = 50_000_000,
  parameter int DataWidth = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Send,
  input  logic [DataWidth-1:0] DataIn,
  input  logic [1:0]           BaudRate,
  input  logic [1:0]           ParityType,
  input  logic                 StopBits,
  output logic                 TxOut,
  output logic                 Busy,
  output logic                 Done
);

  localparam int CntW = (DataWidth > 1) ? $clog2(DataWidth) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DataWidth - 1);

  uartState_t state, stateNext;

  logic [DataWidth-1:0] shiftReg;
  logic [CntW-1:0]      bitCnt;
  logic                 stopCnt;
  logic                 stopTwo;
  logic                 parityEn;
  logic                 parityBit;
  logic [1:0]           baudSel;
  logic                 baudTick;
  logic                 baudClear;
  logic                 txNext;
  logic                 busyNext;
  logic                 doneNext;

  assign baudClear = (state == IDLE);

  uart_baud_tick #(
    .ClkFreq (ClkFreq)
  ) uBaudTick (
    .Clock    (Clock),
    .Reset    (Reset),
    .Clear    (baudClear),
    .BaudRate (baudSel),
    .Tick     (baudTick)
  );

  // Next-state and next-output decode; outputs are registered below so TxOut leads state by nothing.
  always_comb begin
    stateNext = state;
    txNext    = 1'b1;
    busyNext  = 1'b1;
    doneNext  = 1'b0;
    case (state)
      IDLE: begin
        busyNext = 1'b0;
        if (Send) begin
          stateNext = START;
          txNext    = 1'b0;
          busyNext  = 1'b1;
        end
      end
      START: begin
        txNext = 1'b0;
        if (baudTick) begin
          stateNext = DATA;
          txNext    = shiftReg[0];
        end
      end
      DATA: begin
        txNext = shiftReg[0];
        if (baudTick) begin
          if (bitCnt == LastBit) begin
            if (parityEn) begin
              stateNext = PARITY;
              txNext    = parityBit;
            end else begin
              stateNext = STOP;
              txNext    = 1'b1;
            end
          end else begin
            txNext = shiftReg[1];
          end
        end
      end
      PARITY: begin
        txNext = parityBit;
        if (baudTick) begin
          stateNext = STOP;
          txNext    = 1'b1;
        end
      end
      STOP: begin
        if (baudTick && (stopCnt == stopTwo)) begin
          stateNext = IDLE;
          busyNext  = 1'b0;
          doneNext  = 1'b1;
        end
      end
      default: begin
        stateNext = IDLE;
        busyNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      TxOut <= 1'b1;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      state <= stateNext;
      TxOut <= txNext;
      Busy  <= busyNext;
      Done  <= doneNext;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shiftReg  <= '0;
      bitCnt    <= '0;
      stopCnt   <= 1'b0;
      stopTwo   <= 1'b0;
      parityEn  <= 1'b0;
      parityBit <= 1'b0;
      baudSel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Send) begin
            shiftReg  <= DataIn;
            baudSel   <= BaudRate;
            stopTwo   <= StopBits;
            parityEn  <= (ParityType == ParOdd) || (ParityType == ParEven);
            parityBit <= (ParityType == ParOdd) ? ~^DataIn : ^DataIn;
            bitCnt    <= '0;
            stopCnt   <= 1'b0;
          end
        end
        DATA: begin
          if (baudTick) begin
            shiftReg <= shiftReg >> 1;
            bitCnt   <= (bitCnt == LastBit) ? '0 : bitCnt + CntW'(1);
          end
        end
        STOP: begin
          if (baudTick) begin
            stopCnt <= ~stopCnt;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: builds the expected per-cycle line/Busy/Done waveform from the
// frame rules and compares it against the sampled DUT outputs.
module tb_uart_tx_frame;

  localparam int ClkFreq   = 1_000_000;
  localparam int DataWidth = 8;
  localparam int LogMax    = 6000;

  logic       Clock;
  logic       Reset;
  logic       Send;
  logic [7:0] DataIn;
  logic [1:0] BaudRate;
  logic [1:0] ParityType;
  logic       StopBits;
  logic       TxOut;
  logic       Busy;
  logic       Done;

  int compared = 0;
  int mismatched = 0;

  logic lineLog [LogMax];
  logic busyLog [LogMax];
  logic doneLog [LogMax];
  logic expLine [LogMax];
  logic expBusy [LogMax];
  logic expDone [LogMax];

  uart_tx_frame #(
    .ClkFreq   (ClkFreq),
    .DataWidth (DataWidth)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Send       (Send),
    .DataIn     (DataIn),
    .BaudRate   (BaudRate),
    .ParityType (ParityType),
    .StopBits   (StopBits),
    .TxOut      (TxOut),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic int divOf(input logic [1:0] code);
    real hz;
    hz = real'(2400 << code);
    return $rtoi(real'(ClkFreq) / hz + 0.5);
  endfunction

  function automatic int frameBits(input logic [1:0] par, input logic stop);
    return 1 + DataWidth + (((par == 2'b01) || (par == 2'b10)) ? 1 : 0) + (stop ? 2 : 1);
  endfunction

  task automatic clearModel();
    for (int i = 0; i < LogMax; i++) begin
      expLine[i] = 1'b1;
      expBusy[i] = 1'b0;
      expDone[i] = 1'b0;
    end
  endtask

  // Expected waveform of one frame whose start bit appears at sample index 'at'.
  task automatic modelFrame(input int at, input logic [7:0] d, input logic [1:0] baud,
                            input logic [1:0] par, input logic stop);
    int   dv;
    int   ones;
    logic bits [$];
    dv   = divOf(baud);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DataWidth; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (par == 2'b01) bits.push_back(((ones % 2) == 0) ? 1'b1 : 1'b0);
    else if (par == 2'b10) bits.push_back(((ones % 2) == 1) ? 1'b1 : 1'b0);
    bits.push_back(1'b1);
    if (stop) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < dv; c++) begin
        expLine[at + b * dv + c] = bits[b];
        expBusy[at + b * dv + c] = 1'b1;
      end
    end
    expDone[at + bits.size() * dv] = 1'b1;
  endtask

  task automatic recordLog(input int len);
    for (int t = 0; t < len; t++) begin
      @(negedge Clock);
      lineLog[t] = TxOut;
      busyLog[t] = Busy;
      doneLog[t] = Done;
    end
  endtask

  // First sample index where each output departs from the model, or -1.
  task automatic diffLogs(input int len, output int lineAt, output int busyAt, output int doneAt);
    lineAt = -1;
    busyAt = -1;
    doneAt = -1;
    for (int t = 0; t < len; t++) begin
      if (lineAt < 0 && lineLog[t] !== expLine[t]) lineAt = t;
      if (busyAt < 0 && busyLog[t] !== expBusy[t]) busyAt = t;
      if (doneAt < 0 && doneLog[t] !== expDone[t]) doneAt = t;
    end
  endtask

  function automatic int firstDone(input int len);
    for (int t = 0; t < len; t++) if (doneLog[t] === 1'b1) return t;
    return -1;
  endfunction

  function automatic int countDone(input int len);
    int n;
    n = 0;
    for (int t = 0; t < len; t++) if (doneLog[t] === 1'b1) n++;
    return n;
  endfunction

  task automatic startFrame(input logic [7:0] d, input logic [1:0] baud, input logic [1:0] par,
                            input logic stop);
    @(negedge Clock);
    DataIn     = d;
    BaudRate   = baud;
    ParityType = par;
    StopBits   = stop;
    Send       = 1'b1;
  endtask

  task automatic test_reset();
    int dv;
    int idleBad;
    dv = divOf(2'b11);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    compared += 3;
    if (TxOut !== 1'b1) begin mismatched++; $display("FAIL reset_tx: got %b expected 1", TxOut); end
    if (Busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0) begin mismatched++; $display("FAIL reset_done: got %b expected 0", Done); end
    Reset = 1'b0;
    startFrame(8'h10, 2'b11, 2'b00, 1'b0);
    fork
      recordLog(3 * dv);
      begin @(negedge Clock); Send = 1'b0; end
    join
    compared += 1;
    if (TxOut !== 1'b0 || Busy !== 1'b1) begin
      mismatched++;
      $display("FAIL pre_reset_data: got tx=%b busy=%b expected tx=0 busy=1", TxOut, Busy);
    end
    #2 Reset = 1'b1;
    #1;
    compared += 3;
    if (TxOut !== 1'b1) begin mismatched++; $display("FAIL midframe_reset_tx: got %b expected 1", TxOut); end
    if (Busy !== 1'b0) begin mismatched++; $display("FAIL midframe_reset_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0) begin mismatched++; $display("FAIL midframe_reset_done: got %b expected 0", Done); end
    @(negedge Clock);
    Reset = 1'b0;
    idleBad = 0;
    for (int t = 0; t < 3 * dv; t++) begin
      @(negedge Clock);
      if (TxOut !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) idleBad++;
    end
    compared += 1;
    if (idleBad !== 0) begin mismatched++; $display("FAIL idle_after_reset: got %0d bad cycles expected 0", idleBad); end
  endtask

  task automatic test_basic();
    int n, la, ba, da, fd;
    n = 10 * divOf(2'b11);
    clearModel();
    modelFrame(0, 8'hA5, 2'b11, 2'b00, 1'b0);
    startFrame(8'hA5, 2'b11, 2'b00, 1'b0);
    fork
      recordLog(n + 3);
      begin @(negedge Clock); Send = 1'b0; end
    join
    diffLogs(n + 3, la, ba, da);
    fd = firstDone(n + 3);
    compared += 4;
    if (la !== -1) begin mismatched++; $display("FAIL basic_line: got %b at %0d expected %b", lineLog[la], la, expLine[la]); end
    if (ba !== -1) begin mismatched++; $display("FAIL basic_busy: got %b at %0d expected %b", busyLog[ba], ba, expBusy[ba]); end
    if (da !== -1) begin mismatched++; $display("FAIL basic_done: got %b at %0d expected %b", doneLog[da], da, expDone[da]); end
    if (fd !== n) begin mismatched++; $display("FAIL basic_done_latency: got %0d expected %0d", fd, n); end
  endtask

  task automatic test_parity();
    int dv, n, la, ba, da;
    logic [1:0] par;
    dv = divOf(2'b10);
    n  = 11 * dv;
    for (int k = 0; k < 2; k++) begin
      par = (k == 0) ? 2'b01 : 2'b10;
      clearModel();
      modelFrame(0, 8'h07, 2'b10, par, 1'b0);
      startFrame(8'h07, 2'b10, par, 1'b0);
      fork
        recordLog(n + 3);
        begin @(negedge Clock); Send = 1'b0; end
      join
      diffLogs(n + 3, la, ba, da);
      compared += 4;
      if (la !== -1) begin mismatched++; $display("FAIL parity%0d_line: got %b at %0d expected %b", k, lineLog[la], la, expLine[la]); end
      if (ba !== -1) begin mismatched++; $display("FAIL parity%0d_busy: got %b at %0d expected %b", k, busyLog[ba], ba, expBusy[ba]); end
      if (da !== -1) begin mismatched++; $display("FAIL parity%0d_done: got %b at %0d expected %b", k, doneLog[da], da, expDone[da]); end
      if (lineLog[9 * dv + dv / 2] !== ((k == 0) ? 1'b0 : 1'b1)) begin
        mismatched++;
        $display("FAIL parity%0d_bit: got %b expected %b", k, lineLog[9 * dv + dv / 2], (k == 0) ? 1'b0 : 1'b1);
      end
    end
  endtask

  task automatic test_two_stop();
    int n, la, ba, da, fd;
    n = 11 * divOf(2'b00);
    clearModel();
    modelFrame(0, 8'hFF, 2'b00, 2'b00, 1'b1);
    startFrame(8'hFF, 2'b00, 2'b00, 1'b1);
    fork
      recordLog(n + 3);
      begin @(negedge Clock); Send = 1'b0; end
    join
    diffLogs(n + 3, la, ba, da);
    fd = firstDone(n + 3);
    compared += 4;
    if (la !== -1) begin mismatched++; $display("FAIL stop2_line: got %b at %0d expected %b", lineLog[la], la, expLine[la]); end
    if (ba !== -1) begin mismatched++; $display("FAIL stop2_busy: got %b at %0d expected %b", busyLog[ba], ba, expBusy[ba]); end
    if (da !== -1) begin mismatched++; $display("FAIL stop2_done: got %b at %0d expected %b", doneLog[da], da, expDone[da]); end
    if (fd !== n) begin mismatched++; $display("FAIL stop2_done_latency: got %0d expected %0d", fd, n); end
  endtask

  task automatic test_ignore_busy();
    int dv, n, len, la, ba, da, dc;
    dv  = divOf(2'b11);
    n   = 10 * dv;
    len = n + 2 * dv;
    clearModel();
    modelFrame(0, 8'h81, 2'b11, 2'b00, 1'b0);
    startFrame(8'h81, 2'b11, 2'b00, 1'b0);
    fork
      recordLog(len);
      begin
        @(negedge Clock);
        Send = 1'b0;
        repeat (3 * dv) @(negedge Clock);
        DataIn     = 8'h3C;
        BaudRate   = 2'b00;
        ParityType = 2'b01;
        StopBits   = 1'b1;
        Send       = 1'b1;
        @(negedge Clock);
        Send = 1'b0;
      end
    join
    diffLogs(len, la, ba, da);
    dc = countDone(len);
    compared += 4;
    if (la !== -1) begin mismatched++; $display("FAIL ignore_line: got %b at %0d expected %b", lineLog[la], la, expLine[la]); end
    if (ba !== -1) begin mismatched++; $display("FAIL ignore_busy: got %b at %0d expected %b", busyLog[ba], ba, expBusy[ba]); end
    if (da !== -1) begin mismatched++; $display("FAIL ignore_done: got %b at %0d expected %b", doneLog[da], da, expDone[da]); end
    if (dc !== 1) begin mismatched++; $display("FAIL ignore_done_count: got %0d expected 1", dc); end
  endtask

  task automatic test_back_to_back();
    int n, len, la, ba, da;
    n   = 10 * divOf(2'b11);
    len = 2 * n + 4;
    clearModel();
    modelFrame(0, 8'h55, 2'b11, 2'b00, 1'b0);
    modelFrame(n + 1, 8'hAA, 2'b11, 2'b00, 1'b0);
    startFrame(8'h55, 2'b11, 2'b00, 1'b0);
    fork
      recordLog(len);
      begin
        repeat (5) @(negedge Clock);
        DataIn = 8'hAA;
        repeat (n - 3) @(negedge Clock);
        Send = 1'b0;
      end
    join
    diffLogs(len, la, ba, da);
    compared += 4;
    if (la !== -1) begin mismatched++; $display("FAIL b2b_line: got %b at %0d expected %b", lineLog[la], la, expLine[la]); end
    if (ba !== -1) begin mismatched++; $display("FAIL b2b_busy: got %b at %0d expected %b", busyLog[ba], ba, expBusy[ba]); end
    if (da !== -1) begin mismatched++; $display("FAIL b2b_done: got %b at %0d expected %b", doneLog[da], da, expDone[da]); end
    if (doneLog[n] !== 1'b1 || lineLog[n] !== 1'b1 || lineLog[n + 1] !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b_gap: got done=%b line=%b next=%b expected 1 1 0", doneLog[n], lineLog[n], lineLog[n + 1]);
    end
  endtask

  task automatic test_random();
    int n, la, ba, da;
    logic [7:0] d;
    logic [1:0] baud, par;
    logic stop;
    for (int k = 0; k < 6; k++) begin
      d    = 8'($urandom);
      baud = 2'($urandom_range(2, 3));
      par  = 2'($urandom_range(0, 3));
      stop = 1'($urandom_range(0, 1));
      n    = frameBits(par, stop) * divOf(baud);
      clearModel();
      modelFrame(0, d, baud, par, stop);
      startFrame(d, baud, par, stop);
      fork
        recordLog(n + 3);
        begin @(negedge Clock); Send = 1'b0; end
      join
      diffLogs(n + 3, la, ba, da);
      compared += 3;
      if (la !== -1) begin mismatched++; $display("FAIL rand%0d_line d=%h p=%b s=%b: got %b at %0d expected %b", k, d, par, stop, lineLog[la], la, expLine[la]); end
      if (ba !== -1) begin mismatched++; $display("FAIL rand%0d_busy: got %b at %0d expected %b", k, busyLog[ba], ba, expBusy[ba]); end
      if (da !== -1) begin mismatched++; $display("FAIL rand%0d_done: got %b at %0d expected %b", k, doneLog[da], da, expDone[da]); end
    end
  endtask

  initial begin
    Reset      = 1'b1;
    Send       = 1'b0;
    DataIn     = 8'h00;
    BaudRate   = 2'b00;
    ParityType = 2'b00;
    StopBits   = 1'b0;
    test_reset();
    test_basic();
    test_parity();
    test_two_stop();
    test_ignore_busy();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmitter for the UART: accepts one byte over a strobe handshake and shifts it out LSB-first as start, data, optional parity and stop bits at a selectable baud rate. It is the transmit-side counterpart of the oversampling receiver. It runs from the same 50 MHz system clock and uses the same 2-bit baud-rate code. Its TxOut line is the serial input to a receiver.

## Interface
Parameters:
- ClkFreq, 50_000_000: system clock frequency in Hz; baud divisors are derived from it.
- DataWidth, 8: data bits per frame.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Send  in  1  start request; sampled only in IDLE.
- DataIn  in  DataWidth  byte to transmit; latched on accept.
- BaudRate  in  2  baud select: 00=2400, 01=4800, 10=9600, 11=19200; latched on accept.
- ParityType  in  2  parity select: 00=none, 01=odd, 10=even, 11=none; latched on accept.
- StopBits  in  1  stop-bit count: 0=one, 1=two; latched on accept.
- TxOut  out  1  serial line, idle high. Reset value 1.
- Busy  out  1  frame in progress. Reset value 0.
- Done  out  1  one-cycle pulse at frame end. Reset value 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE → START when Send=1. This is the accept event.
  - On accept, latch DataIn into the shift register, latch BaudRate, ParityType and StopBits, and compute parity.
  - Clear the baud counter on accept.
- START → DATA after one bit period. TxOut=0 during START.
- DATA shifts the register right; TxOut is bit 0. After DataWidth bit periods:
  - go to PARITY if the latched ParityType is 01 or 10;
  - otherwise go to STOP.
- PARITY drives one bit for one period:
  - odd: TxOut = ~^data;
  - even: TxOut = ^data.
  - Then go to STOP.
- STOP drives TxOut=1 for 1 or 2 bit periods, then returns to IDLE.
- Send while Busy is ignored; there is no queue. Input changes after accept have no effect on the current frame.
- Reset mid-frame: state returns to IDLE immediately (asynchronous), TxOut=1, Busy=0, Done=0, all counters 0. No partial frame resumes.

## Timing
- Divisor = ClkFreq/baud, rounded: 20833, 10417, 5208, 2604 for codes 00..11.
- Baud counter width: 15 bits. It counts 0..Divisor-1. The terminal count ends the current bit.
- TxOut, Busy and Done are registered outputs. No combinational path from inputs to outputs.
- Accept at edge k: at k+1, TxOut=0 and Busy=1.
- Every bit holds for exactly Divisor cycles.
- Frame length N = (1 + DataWidth + P + S) × Divisor cycles, where P∈{0,1} and S∈{1,2}.
- End of frame, at edge k+N:
  - state=IDLE, Busy=0, Done=1 for one cycle;
  - TxOut is already 1 from the stop bits and stays 1.
- Send=1 during the Done cycle is accepted (back-to-back frames). The next start bit begins at edge k+N+1, so the gap between frames is zero bit periods.
- Send held high continuously produces back-to-back frames.

## Structure
- Shared package/header uart_pkg: the baud-code and parity-code constants, the divisor table, and the state encoding. The receiver uses the same package.
- Sub-module uart_baud_tick:
  - inputs: Clock, Reset, a clear, and the latched BaudRate;
  - output: a one-cycle Tick at the terminal count.
  - It is the 1× counterpart of the receiver's oversampling generator.
- The top level holds the FSM, shift register, bit counter (3 bits for 8 data bits, plus a stop counter) and the parity register.

## Test plan
- Reset asserted mid-frame (during DATA) → TxOut=1, Busy=0 on the next sample. Idle line stays high after release with no Send.
- BaudRate=11, ParityType=00, StopBits=0, DataIn=8'hA5, Send for 1 cycle → line sequence 0, 1,0,1,0,0,1,0,1, 1. Each bit lasts 2604 cycles. Done asserts 26040 cycles after accept.
- BaudRate=10, ParityType=01 (odd), DataIn=8'h07 → parity bit 0. Repeat with ParityType=10 (even) → parity bit 1. Frame length 11×5208 cycles.
- StopBits=1, BaudRate=00, DataIn=8'hFF, no parity → stop level held for 41666 cycles. Total frame 11×20833 cycles.
- Send pulsed again while Busy, with DataIn changed to 8'h3C mid-frame → ignored; the transmitted byte stays the originally latched value. Only one Done pulse.
- Send held high, DataIn=8'h55 then 8'hAA → two frames with zero idle gap. The second start bit follows the first frame's last stop bit by exactly one cycle after Done.
